// File: rtl/fb_pkg.sv
// Shared types and defaults for the single-port framebuffer responder.
package fb_pkg;

  localparam int FB_WORD_WIDTH          = 16;
  localparam int FB_DEFAULT_INDEX_WIDTH = 14;
  localparam int FB_DEFAULT_SIZE        = 16384;

  typedef logic [FB_WORD_WIDTH-1:0] fb_word_t;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN
  } fb_state_e;

endpackage

// File: rtl/framebuffer_sp_ram.sv
// Inferred single-port RAM with a registered read port; a write suppresses the read.
module framebuffer_sp_ram
  import fb_pkg::*;
#(
  parameter int ADDR_WIDTH = FB_DEFAULT_INDEX_WIDTH
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  fb_word_t              wdata,
  output fb_word_t              rdata
);

  fb_word_t mem [2**ADDR_WIDTH];

  // One access per cycle: write, or registered read.
  // NOTE: storage arrays get no reset so the tools can map them onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/framebuffer_sp_responder.sv
// Framebuffer responder on one single-port RAM: pipeline read/write ports,
// clear engine and AXI-Stream readout engine.
// Optional feature: define FRAMEBUFFER_COLLISION_CHECK_EN to build the sticky
// collision detector; otherwise collision is tied low.
module framebuffer_sp_responder
  import fb_pkg::*;
#(
  parameter int FRAMEBUFFER_INDEX_WIDTH = FB_DEFAULT_INDEX_WIDTH,
  parameter int FRAMEBUFFER_SIZE        = FB_DEFAULT_SIZE
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               pixelInPipeline,
  input  logic                               colorReadEnable,
  input  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] colorIndexRead,
  output fb_word_t                           colorIn,
  input  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] colorIndexWrite,
  input  logic                               colorWriteEnable,
  input  fb_word_t                           colorOut,
  input  logic                               cmdClear,
  input  logic                               cmdStream,
  input  fb_word_t                           clearColor,
  output logic                               busy,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic                               m_axis_tlast,
  output fb_word_t                           m_axis_tdata,
  output logic                               collision
);

  // One extra bit so a size equal to the full address space ends without wrapping.
  localparam int             AW        = FRAMEBUFFER_INDEX_WIDTH + 1;
  localparam logic [AW-1:0]  LAST_ADDR = AW'(FRAMEBUFFER_SIZE - 1);

  fb_state_e state_q, state_d;
  logic [AW-1:0] addr_q;
  fb_word_t      clear_q;

  logic                               ram_en, ram_we;
  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] ram_addr;
  fb_word_t                           ram_wdata, ram_rdata;

  logic     pipe_rd, pipe_rd_q;
  fb_word_t color_hold_q;

  logic     rd_inflight_q, rd_last_q;
  fb_word_t buf0_data_q, buf1_data_q;
  logic     buf0_last_q, buf1_last_q;
  logic [1:0] buf_count_q;

  logic       accept, pop, push, stream_issue, at_last;
  logic [2:0] occ, occ_after_pop;

  assign accept = (state_q == IDLE) && !pixelInPipeline && !colorWriteEnable &&
                  (cmdClear || cmdStream);
  assign at_last = (addr_q == LAST_ADDR);
  assign pop  = m_axis_tvalid && m_axis_tready;
  assign push = rd_inflight_q;
  // Skid occupancy counts the read in flight, so a new read only issues if it
  // is guaranteed a slot when its data lands.
  assign occ           = {1'b0, buf_count_q} + {2'b00, rd_inflight_q};
  assign occ_after_pop = occ - {2'b00, pop};
  assign stream_issue  = (state_q == STREAM) && (occ_after_pop <= 3'd1);

  // State register; reset aborts any bulk operation.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (accept) state_d = cmdClear ? CLEAR : STREAM;
      CLEAR:  if (at_last) state_d = IDLE;
      STREAM: if (stream_issue && at_last) state_d = DRAIN;
      DRAIN:  if (occ_after_pop == 3'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM port arbitration: pipeline write > pipeline read in IDLE, engines otherwise.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = addr_q[FRAMEBUFFER_INDEX_WIDTH-1:0];
    ram_wdata = clear_q;
    pipe_rd   = 1'b0;
    case (state_q)
      IDLE: begin
        if (colorWriteEnable) begin
          ram_we    = 1'b1;
          ram_addr  = colorIndexWrite;
          ram_wdata = colorOut;
        end else if (colorReadEnable) begin
          ram_en   = 1'b1;
          ram_addr = colorIndexRead;
          pipe_rd  = 1'b1;
        end
      end
      CLEAR:   ram_we = 1'b1;
      STREAM:  ram_en = stream_issue;
      default: ;
    endcase
  end

  assign busy = (state_q != IDLE);

  framebuffer_sp_ram #(.ADDR_WIDTH(FRAMEBUFFER_INDEX_WIDTH)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Engine address counter, fill value and read-tracking flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q        <= '0;
      clear_q       <= '0;
      pipe_rd_q     <= 1'b0;
      color_hold_q  <= '0;
      rd_inflight_q <= 1'b0;
      rd_last_q     <= 1'b0;
    end else begin
      pipe_rd_q     <= pipe_rd;
      color_hold_q  <= colorIn;
      rd_inflight_q <= stream_issue;
      rd_last_q     <= stream_issue && at_last;
      if (accept) begin
        addr_q  <= '0;
        clear_q <= clearColor;
      end else if ((state_q == CLEAR) || stream_issue) begin
        addr_q <= addr_q + 1'b1;
      end
    end
  end

  // Pipeline read data appears the cycle after the read; otherwise colorIn holds.
  assign colorIn = pipe_rd_q ? ram_rdata : color_hold_q;

  // Two-entry output skid buffer; head entry drives the AXIS outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf0_data_q <= '0;
      buf1_data_q <= '0;
      buf0_last_q <= 1'b0;
      buf1_last_q <= 1'b0;
      buf_count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (buf_count_q == 2'd0) begin
            buf0_data_q <= ram_rdata;
            buf0_last_q <= rd_last_q;
          end else begin
            buf1_data_q <= ram_rdata;
            buf1_last_q <= rd_last_q;
          end
          buf_count_q <= buf_count_q + 2'd1;
        end
        2'b01: begin
          buf0_data_q <= buf1_data_q;
          buf0_last_q <= buf1_last_q;
          buf_count_q <= buf_count_q - 2'd1;
        end
        2'b11: begin
          if (buf_count_q == 2'd1) begin
            buf0_data_q <= ram_rdata;
            buf0_last_q <= rd_last_q;
          end else begin
            buf0_data_q <= buf1_data_q;
            buf0_last_q <= buf1_last_q;
            buf1_data_q <= ram_rdata;
            buf1_last_q <= rd_last_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_axis_tvalid = (buf_count_q != 2'd0);
  assign m_axis_tdata  = buf0_data_q;
  assign m_axis_tlast  = buf0_last_q;

`ifdef FRAMEBUFFER_COLLISION_CHECK_EN
  logic collision_q;

  // Sticky flag: same-cycle read/write in IDLE, or any pipeline access while an engine owns the RAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      collision_q <= 1'b0;
    end else if (((state_q == IDLE) && colorReadEnable && colorWriteEnable) ||
                 ((state_q != IDLE) && (colorReadEnable || colorWriteEnable))) begin
      collision_q <= 1'b1;
    end
  end

  assign collision = collision_q;
`else
  assign collision = 1'b0;
`endif

endmodule
